crc_engine_param: RTL and testbench

//  Parametrised multi-bit-per-cycle CRC engine for the IoT data-filtering datapath.
//  On an enable pulse it captures one DATA_W-bit word and processes it MSB first,
//  BPC bits per cycle.
//  GEN mode returns the CRC remainder; CHECK mode also flags whether the word

---
 rtl/crc_engine_param_pkg.sv | 31 +++
 rtl/crc_engine_param_if.sv | 25 ++
 rtl/crc_engine_param_step.sv | 27 ++
 rtl/crc_engine_param.sv | 107 ++++++++++
 tb/tb_crc_engine_param.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/crc_engine_param_pkg.sv
// Shared types and the single-bit CRC update used by the multi-bit CRC engine.
// crc_bit works on a fixed 32-bit container so one function serves every CRC_W.
package crc_engine_param_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DONE
  } state_t;

  localparam logic MODE_GEN   = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

  localparam int unsigned MAX_CRC_W = 32;

  // One MSB-first LFSR step; bits above crc_w are forced to zero.
  function automatic logic [MAX_CRC_W-1:0] crc_bit(
    input logic [MAX_CRC_W-1:0] r,
    input logic                 b,
    input logic [MAX_CRC_W-1:0] poly,
    input int unsigned          crc_w
  );
    logic                 fb;
    logic [MAX_CRC_W-1:0] mask;
    mask = (crc_w >= MAX_CRC_W) ? '1 : ((MAX_CRC_W'(1) << crc_w) - MAX_CRC_W'(1));
    fb   = r[5'(crc_w - 1)] ^ b;
    return ((r << 1) ^ (fb ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/crc_engine_param_if.sv
// Request/result bundle between a CRC engine client (master) and the engine (slave).
interface crc_engine_param_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CRC_W  = 3
) ();

  logic              en;
  logic              i_mode;
  logic [DATA_W-1:0] i_data;
  logic              o_busy;
  logic              o_valid;
  logic [CRC_W-1:0]  o_data;
  logic              o_match;

  modport master (
    output en, i_mode, i_data,
    input  o_busy, o_valid, o_data, o_match
  );

  modport slave (
    input  en, i_mode, i_data,
    output o_busy, o_valid, o_data, o_match
  );

endinterface

// File: rtl/crc_engine_param_step.sv
// Combinational BPC-deep unroll of crc_bit; this is the engine's critical path.
module crc_engine_param_step
  import crc_engine_param_pkg::*;
#(
  parameter int unsigned      CRC_W = 3,
  parameter logic [CRC_W-1:0] POLY  = 3'b011,
  parameter int unsigned      BPC   = 4
) (
  input  logic [CRC_W-1:0] i_r,
  input  logic [BPC-1:0]   i_bits,
  output logic [CRC_W-1:0] o_r_next
);

  localparam logic [MAX_CRC_W-1:0] POLY_EXT = MAX_CRC_W'(POLY);

  logic [CRC_W-1:0] w_r;

  // i_bits[BPC-1] is the oldest bit and is folded in first.
  always_comb begin
    w_r = i_r;
    for (int unsigned i = 0; i < BPC; i++) begin
      w_r = CRC_W'(crc_bit(MAX_CRC_W'(w_r), i_bits[BPC-1-i], POLY_EXT, CRC_W));
    end
    o_r_next = w_r;
  end

endmodule

// File: rtl/crc_engine_param.sv
// Parametrised CRC engine: captures one word on en, consumes it BPC bits per
// cycle MSB first, then emits the remainder (and a zero-remainder flag in CHECK mode).
module crc_engine_param
  import crc_engine_param_pkg::*;
#(
  parameter int unsigned      DATA_W = 128,
  parameter int unsigned      CRC_W  = 3,
  parameter logic [CRC_W-1:0] POLY   = 3'b011,
  parameter int unsigned      BPC    = 4,
  parameter logic [CRC_W-1:0] INIT   = '0
) (
  input logic              clk,
  input logic              rst,
  crc_engine_param_if.slave bus
);

  localparam int unsigned STEPS = DATA_W / BPC;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  if (BPC < 1 || BPC > DATA_W) begin : g_chk_bpc_range
    $error("crc_engine_param: BPC must be in 1..DATA_W");
  end
  if ((DATA_W % BPC) != 0) begin : g_chk_bpc_div
    $error("crc_engine_param: DATA_W must be a multiple of BPC");
  end
  if (CRC_W < 2 || CRC_W > MAX_CRC_W) begin : g_chk_crc_w
    $error("crc_engine_param: CRC_W must be in 2..32");
  end
  if (POLY[0] != 1'b1) begin : g_chk_poly
    $error("crc_engine_param: POLY[0] must be 1");
  end

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_shift;
  logic              r_mode;
  logic [CRC_W-1:0]  r_crc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [CRC_W-1:0]  r_data;
  logic              r_match;
  logic [CRC_W-1:0]  w_crc_next;

  crc_engine_param_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .BPC   (BPC)
  ) u_step (
    .i_r      (r_crc),
    .i_bits   (r_shift[DATA_W-1 -: BPC]),
    .o_r_next (w_crc_next)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.en) w_next = LOAD;
      LOAD:    w_next = CALC;
      CALC:    if (r_cnt == CNT_W'(STEPS - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_mode  <= 1'b0;
      r_crc   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_shift <= bus.i_data;
            r_mode  <= bus.i_mode;
          end
        end
        LOAD: begin
          r_crc <= INIT;
          r_cnt <= '0;
        end
        CALC: begin
          r_crc   <= w_crc_next;
          r_shift <= r_shift << BPC;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
      // Result registers are zeroed outside the single valid cycle.
      r_valid <= (r_state == DONE);
      r_data  <= (r_state == DONE) ? r_crc : '0;
      r_match <= (r_state == DONE) && (r_mode == MODE_CHECK) && (r_crc == '0);
    end
  end

  assign bus.o_busy  = (r_state != IDLE);
  assign bus.o_valid = r_valid;
  assign bus.o_data  = r_data;
  assign bus.o_match = r_match;

endmodule

// File: tb/tb_crc_engine_param.sv
// Scoreboard bench for crc_engine_param at BPC=4 (default), BPC=1 and BPC=128.
module tb_crc_engine_param;
  import crc_engine_param_pkg::*;

  localparam int unsigned DW   = 128;
  localparam int unsigned CW   = 3;
  localparam logic [3:0]  GPOL = 4'b1011;

  typedef struct {
    logic [2:0] crc;
    logic       match;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crc_engine_param_if #(.DATA_W(DW), .CRC_W(CW)) if_d  ();
  crc_engine_param_if #(.DATA_W(DW), .CRC_W(CW)) if_b1 ();
  crc_engine_param_if #(.DATA_W(DW), .CRC_W(CW)) if_bf ();

  crc_engine_param u_dut_d (.clk(clk), .rst(rst), .bus(if_d));
  crc_engine_param #(.BPC(1))   u_dut_b1 (.clk(clk), .rst(rst), .bus(if_b1));
  crc_engine_param #(.BPC(128)) u_dut_bf (.clk(clk), .rst(rst), .bus(if_bf));

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   lat[3] = '{34, 130, 3};

  // Reference: long division of M(x)*x^3 by G(x) = x^3 + x + 1.
  function automatic logic [2:0] ref_crc(input logic [DW-1:0] x);
    logic [DW+2:0] t;
    t = {x, 3'b000};
    for (int i = DW + 2; i >= 3; i--) begin
      if (t[i]) t[i -: 4] = t[i -: 4] ^ GPOL;
    end
    return t[2:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic e, input logic m, input logic [DW-1:0] x);
    case (d)
      0:       begin if_d.en  = e; if_d.i_mode  = m; if_d.i_data  = x; end
      1:       begin if_b1.en = e; if_b1.i_mode = m; if_b1.i_data = x; end
      default: begin if_bf.en = e; if_bf.i_mode = m; if_bf.i_data = x; end
    endcase
  endtask

  task automatic sample(input int d, output logic v, output logic b,
                        output logic [2:0] o, output logic mt);
    case (d)
      0:       begin v = if_d.o_valid;  b = if_d.o_busy;  o = if_d.o_data;  mt = if_d.o_match;  end
      1:       begin v = if_b1.o_valid; b = if_b1.o_busy; o = if_b1.o_data; mt = if_b1.o_match; end
      default: begin v = if_bf.o_valid; b = if_bf.o_busy; o = if_bf.o_data; mt = if_bf.o_match; end
    endcase
  endtask

  task automatic check_result(input string tag, input logic [2:0] o, input logic mt);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_crc"}, 32'(o), 32'(e.crc));
      chk({tag, "_match"}, 32'(mt), 32'(e.match));
    end
  endtask

  // One job: inputs are scrambled right after capture to prove they are latched.
  task automatic run_job(input int d, input string tag, input logic m, input logic [DW-1:0] x,
                         input logic [2:0] ecrc, input logic emat, input bit full);
    exp_t e;
    int   cyc;
    logic v, b, mt;
    logic [2:0] o;
    e.crc = ecrc; e.match = emat;
    sbq.push_back(e);
    drive(d, 1'b1, m, x);
    @(posedge clk); #1;
    drive(d, 1'b0, ~m, ~x);
    cyc = 0;
    sample(d, v, b, o, mt);
    while (!v && cyc <= 200) begin
      @(posedge clk); #1;
      cyc++;
      sample(d, v, b, o, mt);
    end
    if (full) chk({tag, "_latency"}, 32'(cyc), 32'(lat[d]));
    else if (cyc > 200) chk({tag, "_timeout"}, 32'(cyc), 32'(lat[d]));
    check_result(tag, o, mt);
    @(posedge clk); #1;
    sample(d, v, b, o, mt);
    if (full) begin
      chk({tag, "_valid_drop"}, 32'(v), 32'd0);
      chk({tag, "_data_idle"}, 32'(o), 32'd0);
    end
  endtask

  initial begin
    logic v, b, mt;
    logic [2:0] o;
    logic [DW-1:0] x;
    int nval, first_at, second_at;

    for (int d = 0; d < 3; d++) drive(d, 1'b0, MODE_GEN, '0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      sample(d, v, b, o, mt);
      chk("rst_valid", 32'(v), 32'd0);
      chk("rst_busy",  32'(b), 32'd0);
      chk("rst_data",  32'(o), 32'd0);
      chk("rst_match", 32'(mt), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(0, "gen_h0", MODE_GEN, 128'h0, 3'b000, 1'b0, 1'b1);
    run_job(0, "gen_h1", MODE_GEN, 128'h1, 3'b011, 1'b0, 1'b1);
    run_job(0, "gen_h2", MODE_GEN, 128'h2, 3'b110, 1'b0, 1'b1);
    run_job(0, "gen_hb", MODE_GEN, 128'hB, 3'b000, 1'b0, 1'b1);
    run_job(0, "chk_hb", MODE_CHECK, 128'hB, 3'b000, 1'b1, 1'b1);
    run_job(0, "chk_ha", MODE_CHECK, 128'hA, 3'b011, 1'b0, 1'b1);

    // en held 40 edges: second job taken in the IDLE cycle after the first DONE.
    sbq.push_back('{crc: 3'b011, match: 1'b0});
    sbq.push_back('{crc: 3'b011, match: 1'b0});
    drive(0, 1'b1, MODE_GEN, 128'h1);
    nval = 0; first_at = -1; second_at = -1;
    for (int k = 0; k < 110; k++) begin
      @(posedge clk); #1;
      if (k == 39) drive(0, 1'b0, MODE_GEN, 128'h1);
      sample(0, v, b, o, mt);
      if (v) begin
        nval++;
        if (nval == 1) first_at = k; else if (nval == 2) second_at = k;
        check_result("hold", o, mt);
      end
    end
    chk("hold_count",  32'(nval), 32'd2);
    chk("hold_first",  32'(first_at), 32'd34);
    chk("hold_second", 32'(second_at), 32'd69);
    sbq.delete();

    // Asynchronous reset mid-job discards the job.
    drive(0, 1'b1, MODE_GEN, 128'h2);
    @(posedge clk); #1;
    drive(0, 1'b0, MODE_GEN, 128'h0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sample(0, v, b, o, mt);
    chk("midrst_busy",  32'(b), 32'd0);
    chk("midrst_valid", 32'(v), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nval = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      sample(0, v, b, o, mt);
      if (v) nval++;
    end
    chk("midrst_no_valid", 32'(nval), 32'd0);
    run_job(0, "post_rst_h2", MODE_GEN, 128'h2, 3'b110, 1'b0, 1'b1);

    run_job(1, "bpc1_h1",   MODE_GEN, 128'h1, 3'b011, 1'b0, 1'b1);
    run_job(1, "bpc1_h2",   MODE_GEN, 128'h2, 3'b110, 1'b0, 1'b1);
    run_job(2, "bpc128_h1", MODE_GEN, 128'h1, 3'b011, 1'b0, 1'b1);
    run_job(2, "bpc128_h2", MODE_GEN, 128'h2, 3'b110, 1'b0, 1'b1);
    run_job(2, "bpc128_chk_hb", MODE_CHECK, 128'hB, 3'b000, 1'b1, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      run_job(0, "rnd_gen", MODE_GEN, x, ref_crc(x), 1'b0, 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      // Every other word is turned into a codeword by appending its own CRC.
      if (i % 2 == 0) x = {x[DW-4:0], ref_crc({3'b000, x[DW-4:0]})};
      run_job(0, "rnd_chk", MODE_CHECK, x, ref_crc(x), ref_crc(x) == 3'b000, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
